binary_xnor_linear: RTL and testbench
=====================================

Name: binary_xnor_linear

Overview:
Parametrised successor to the fixed 16-in/64-out binary intermediate layer. Computes a binarised dense layer, out[c] = sign(2*popcount(XNOR(x, W[c])) - N) > THRESH, over an input vector of BEAT_W*IN_BEATS bits delivered as IN_BEATS beats per token. Weights are read from an external ROM. Tokens are counted, and done is raised after NUM_TOKENS tokens. Valid/ready handshake on both data sides; sits between attention output binarisation and the next binary stage.

Parameters:
BEAT_W, 16, input bits per beat
IN_BEATS, 4, beats per token; N = BEAT_W*IN_BEATS
OUT_CH, 64, output channels (bits per output token)
NUM_BLOCKS, 4, weight blocks selectable by block_sel
NUM_TOKENS, 30, tokens per sequence before done
THRESH, 0, signed threshold; bit = ((2*acc - N) > THRESH)

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
clear  in  1  synchronous sequence restart: counters, accumulators, done, out_valid -> 0
block_sel  in  $clog2(NUM_BLOCKS)  weight block; sampled on first beat of each token
in_data  in  BEAT_W  input beat
in_valid  in  1  beat valid
in_ready  out  1  beat accepted when in_valid & in_ready
w_rd_en  out  1  weight ROM read enable
w_addr  out  $clog2(NUM_BLOCKS*IN_BEATS)  = sel_q*IN_BEATS + beat_idx
w_data  in  OUT_CH*BEAT_W  ROM data, valid 1 cycle after w_rd_en; channel c = w_data[c*BEAT_W +: BEAT_W]
out_data  out  OUT_CH  binarised token
out_valid  out  1  out_data valid, held until out_ready
out_ready  in  1  downstream accept
done  out  1  sticky; NUM_TOKENS tokens handshaken

Behaviour:
- Reset (rst=1 at clk edge): in_ready=0, out_valid=0, out_data=0, done=0, w_rd_en=0, beat_idx=0, tok_cnt=0, all acc=0, state=ACCUM. in_ready=1 from the first cycle after reset release. clear has identical effect; rst has priority over clear.
- ACC_W = $clog2(N+1), unsigned per channel; comparison done in signed ACC_W+2 bits.
- States: ACCUM, DRAIN, EMIT, DONE.
- ACCUM: in_ready=1. On accept: w_rd_en=1 combinationally, w_addr as above (for beat 0, w_addr uses the current block_sel and registers it into sel_q), in_data registered into x_q, beat_idx++. Next cycle: acc[c] += popcount(~(w_data_c ^ x_q)); on beat 0 acc is loaded, not added. Accept of the last beat (beat_idx==IN_BEATS-1) -> DRAIN, in_ready=0, beat_idx=0.
- DRAIN (1 cycle): final accumulate; out_data[c] <= ((2*acc_final - N) > THRESH) -> EMIT with out_valid=1. Latency: last-beat accept at cycle t, out_valid high at t+2.
- EMIT: out_data and out_valid stable until out_ready. On handshake: tok_cnt++. If tok_cnt reaches NUM_TOKENS -> DONE with done=1; else -> ACCUM with in_ready=1 the next cycle (no overlap between tokens).
- DONE: in_ready=0, out_valid=0, done held until rst/clear.
- block_sel changes mid-token are ignored; sel_q governs all beats of the token.
- in_valid low between beats: stall; partial accumulation retained indefinitely.
- clear mid-token or mid-EMIT: the partial token is discarded and out_valid drops next cycle.
- 2*acc - N == THRESH yields 0 (strict compare). With THRESH=0, exact balance -> 0.

Decomposition:
- Package binary_layer_pkg: ACC_W/ADDR_W derivation functions, state enum, and a popcount function.
- One sub-module, xnor_popcount (BEAT_W-bit XNOR and adder tree, combinational, instanced OUT_CH times via generate).

Test Plan:
1. BEAT_W=16, IN_BEATS=1, in_data=16'hFFFF, all weights 16'hFFFF -> acc=16, out_data=all 1s at t+2, stable while out_ready=0 for 5 cycles.
2. Defaults; weights = bitwise inverse of input on all 4 beats -> acc=0, out_data=64'h0; half-matching input (acc=32) -> 0 (strict); acc=33 -> 1.
3. block_sel=2 at beat 0, changed to 1 on beat 2 -> w_addr sequence 8,9,10,11, not 8,9,6,7.
4. in_valid gaps of 3 cycles between beats -> same out_data as back-to-back; in_ready drops exactly in DRAIN/EMIT.
5. Stream 30 tokens with out_ready always 1 -> done rises the cycle after the 30th handshake; in_ready stays 0 afterwards; clear pulse -> done=0, in_ready=1 next cycle.
6. rst asserted during the DRAIN of token 5 -> all outputs 0 next edge; token 0 after release is computed correctly with no stale accumulation.

Source files
------------

// File: rtl/binary_xnor_linear_pkg.sv
// ----------------------------------------------------------------------------
// binary_layer_pkg
// Shared types and helpers for the binarised XNOR dense layer.
//   state_t      : token sequencing FSM states
//   beat_tag_t   : side-band tag travelling with a beat into the accumulate stage
//   acc_w/addr_w : width derivations used by ports and datapath
//   popcount     : population count of a (zero-extended) bit vector
// ----------------------------------------------------------------------------
package binary_layer_pkg;

   typedef enum logic [1:0] {
      ACCUM = 2'd0,
      DRAIN = 2'd1,
      EMIT  = 2'd2,
      DONE  = 2'd3
   } state_t;

   // first: load the accumulator instead of adding; last: closes the token
   typedef struct packed {
      logic first;
      logic last;
   } beat_tag_t;

   // Widest beat that popcount() accepts; narrower beats are zero-extended.
   localparam int POP_MAX = 256;

   // $clog2 that never returns 0, so single-entry ranges still get a 1-bit field
   function automatic int clog2_min1(input int v);
      return (v <= 1) ? 1 : $clog2(v);
   endfunction

   // Unsigned width able to hold a count 0..n
   function automatic int acc_w(input int n);
      return $clog2(n + 1);
   endfunction

   function automatic int addr_w(input int blocks, input int beats);
      return clog2_min1(blocks * beats);
   endfunction

   function automatic int unsigned popcount(input logic [POP_MAX-1:0] v);
      int unsigned s;
      s = 0;
      for (int i = 0; i < POP_MAX; i++) s += 32'(v[i]);
      return s;
   endfunction

endpackage

// File: rtl/binary_xnor_linear_if.sv
// ----------------------------------------------------------------------------
// binary_xnor_linear_if
// Data-side bundle of the XNOR layer: input beat stream, weight ROM port and
// output token stream.
//   slave  : the layer (consumes beats/ROM data, produces tokens)
//   master : the surrounding logic (beat source, ROM, token sink)
// ----------------------------------------------------------------------------
interface binary_xnor_linear_if #(
   parameter int BEAT_W     = 16,
   parameter int IN_BEATS   = 4,
   parameter int OUT_CH     = 64,
   parameter int NUM_BLOCKS = 4
);
   localparam int ADDR_W = binary_layer_pkg::addr_w(NUM_BLOCKS, IN_BEATS);

   logic [BEAT_W-1:0]        in_data;
   logic                     in_valid;
   logic                     in_ready;
   logic                     w_rd_en;
   logic [ADDR_W-1:0]        w_addr;
   logic [OUT_CH*BEAT_W-1:0] w_data;
   logic [OUT_CH-1:0]        out_data;
   logic                     out_valid;
   logic                     out_ready;

   modport slave (
      input  in_data, in_valid, w_data, out_ready,
      output in_ready, w_rd_en, w_addr, out_data, out_valid
   );

   modport master (
      output in_data, in_valid, w_data, out_ready,
      input  in_ready, w_rd_en, w_addr, out_data, out_valid
   );

endinterface

// File: rtl/binary_xnor_linear_xnor_popcount.sv
// ----------------------------------------------------------------------------
// xnor_popcount
// One output channel's share of a beat: counts the bit positions where the
// weight slice and the input beat agree.
//   w   : BEAT_W weight bits for this channel
//   x   : BEAT_W input bits
//   cnt : number of matching positions, 0..BEAT_W
// Purely combinational.
// ----------------------------------------------------------------------------
module xnor_popcount
   import binary_layer_pkg::*;
#(
   parameter int BEAT_W = 16,
   parameter int CNT_W  = acc_w(BEAT_W)
) (
   input  logic [BEAT_W-1:0] w,
   input  logic [BEAT_W-1:0] x,
   output logic [CNT_W-1:0]  cnt
);

   logic [BEAT_W-1:0] match;

   assign match = ~(w ^ x);
   assign cnt   = CNT_W'(popcount(POP_MAX'(match)));

endmodule

// File: rtl/binary_xnor_linear.sv
// ----------------------------------------------------------------------------
// binary_xnor_linear
// Binarised dense layer: each output bit c is
//   ((2*matches(x, W[c]) - N) > THRESH),  N = BEAT_W*IN_BEATS
// with x arriving as IN_BEATS beats per token and W read from an external ROM
// one beat-row at a time. After NUM_TOKENS output handshakes done sticks high.
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   clear      : synchronous sequence restart (same effect as rst)
//   block_sel  : weight block, captured on the first beat of a token
//   done       : sticky end-of-sequence flag
//   bus        : beat input, weight ROM port, token output (slave view)
// Timing: last-beat accept in cycle t, out_valid high from cycle t+2.
// ----------------------------------------------------------------------------
module binary_xnor_linear
   import binary_layer_pkg::*;
#(
   parameter int BEAT_W     = 16,
   parameter int IN_BEATS   = 4,
   parameter int OUT_CH     = 64,
   parameter int NUM_BLOCKS = 4,
   parameter int NUM_TOKENS = 30,
   parameter int THRESH     = 0,
   localparam int SEL_W     = clog2_min1(NUM_BLOCKS)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clear,
   input  logic [SEL_W-1:0] block_sel,
   output logic             done,
   binary_xnor_linear_if.slave bus
);

   localparam int N      = BEAT_W * IN_BEATS;
   localparam int ACC_W  = acc_w(N);
   localparam int CNT_W  = acc_w(BEAT_W);
   localparam int CMP_W  = ACC_W + 2;
   localparam int ADDR_W = addr_w(NUM_BLOCKS, IN_BEATS);
   localparam int BI_W   = clog2_min1(IN_BEATS);
   localparam int TOK_W  = acc_w(NUM_TOKENS);

   state_t                        state;
   logic [BI_W-1:0]               beat_idx;
   logic [SEL_W-1:0]              sel_q;
   logic [SEL_W-1:0]              sel_eff;
   logic [BEAT_W-1:0]             x_q;
   beat_tag_t                     tag_q;
   logic                          acc_vld_q;
   logic [TOK_W-1:0]              tok_cnt;
   logic                          accept;
   logic                          first_beat;
   logic                          last_beat;

   logic [OUT_CH-1:0][CNT_W-1:0]  pc;
   logic [OUT_CH-1:0][ACC_W-1:0]  acc;
   logic [OUT_CH-1:0][ACC_W-1:0]  acc_nxt;
   logic [OUT_CH-1:0]             bit_nxt;

   // ------------------------------------------------------------------
   // Beat acceptance and ROM addressing
   // ------------------------------------------------------------------
   // Gated by rst/clear so no beat is taken in a cycle that is restarting
   // the sequence, and so the port opens the first cycle those drop.
   assign bus.in_ready = (state == ACCUM) && !rst && !clear;
   assign accept       = bus.in_valid && bus.in_ready;

   assign first_beat   = (beat_idx == '0);
   assign last_beat    = (beat_idx == BI_W'(IN_BEATS - 1));

   // Beat 0 addresses with the live block_sel (the same value lands in
   // sel_q); later beats use the captured copy so mid-token changes are ignored.
   assign sel_eff      = first_beat ? block_sel : sel_q;
   assign bus.w_rd_en  = accept;
   assign bus.w_addr   = ADDR_W'(32'(sel_eff) * IN_BEATS + 32'(beat_idx));

   // ------------------------------------------------------------------
   // Per-channel match counters on the ROM row returned this cycle
   // ------------------------------------------------------------------
   for (genvar c = 0; c < OUT_CH; c++) begin : g_ch
      xnor_popcount #(
         .BEAT_W (BEAT_W),
         .CNT_W  (CNT_W)
      ) u_pc (
         .w   (bus.w_data[c*BEAT_W +: BEAT_W]),
         .x   (x_q),
         .cnt (pc[c])
      );
   end

   always_comb begin
      logic signed [CMP_W-1:0] diff;
      diff    = '0;
      acc_nxt = '0;
      bit_nxt = '0;
      for (int c = 0; c < OUT_CH; c++) begin
         acc_nxt[c] = tag_q.first ? ACC_W'(pc[c]) : acc[c] + ACC_W'(pc[c]);
         // {0,acc,0} is 2*acc, zero-extended to keep it non-negative
         diff       = $signed({1'b0, acc_nxt[c], 1'b0}) - $signed(CMP_W'(N));
         bit_nxt[c] = (diff > $signed(CMP_W'(THRESH)));
      end
   end

   // ------------------------------------------------------------------
   // Sequencing
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst || clear) begin
         state         <= ACCUM;
         beat_idx      <= '0;
         sel_q         <= '0;
         x_q           <= '0;
         tag_q         <= '0;
         acc_vld_q     <= 1'b0;
         acc           <= '0;
         tok_cnt       <= '0;
         bus.out_data  <= '0;
         bus.out_valid <= 1'b0;
         done          <= 1'b0;
      end else begin
         // ROM data for an accepted beat shows up one cycle later; x_q and
         // tag_q are held alongside so the pair meets at the counters.
         acc_vld_q <= accept;
         if (accept) begin
            x_q   <= bus.in_data;
            tag_q <= '{first: first_beat, last: last_beat};
            if (first_beat) sel_q <= block_sel;
         end
         if (acc_vld_q) acc <= acc_nxt;

         case (state)
            ACCUM: begin
               if (accept) begin
                  if (last_beat) begin
                     beat_idx <= '0;
                     state    <= DRAIN;
                  end else begin
                     beat_idx <= beat_idx + 1'b1;
                  end
               end
            end
            DRAIN: begin
               // The last beat's row is on w_data now; binarise straight
               // from the final sum rather than waiting for acc.
               if (acc_vld_q && tag_q.last) begin
                  bus.out_data  <= bit_nxt;
                  bus.out_valid <= 1'b1;
                  state         <= EMIT;
               end
            end
            EMIT: begin
               if (bus.out_ready) begin
                  bus.out_valid <= 1'b0;
                  tok_cnt       <= tok_cnt + 1'b1;
                  if (tok_cnt == TOK_W'(NUM_TOKENS - 1)) begin
                     done  <= 1'b1;
                     state <= DONE;
                  end else begin
                     state <= ACCUM;
                  end
               end
            end
            DONE: begin
               // parked until rst/clear
            end
            default: state <= ACCUM;
         endcase
      end
   end

endmodule

// File: tb/tb_binary_xnor_linear.sv
// ----------------------------------------------------------------------------
// tb_binary_xnor_linear
// Directed + randomised bench for binary_xnor_linear. dut0 uses the default
// 16x4-beat shape; dut1 is a single-beat variant. Expected tokens come from a
// bit-matching reference over the bench's own ROM images.
// ----------------------------------------------------------------------------
module tb_binary_xnor_linear;

   localparam int BEAT_W     = 16;
   localparam int IN_BEATS   = 4;
   localparam int OUT_CH     = 64;
   localparam int NUM_BLOCKS = 4;
   localparam int NUM_TOKENS = 30;
   localparam int THRESH     = 0;
   localparam int N          = BEAT_W * IN_BEATS;
   localparam int WD         = OUT_CH * BEAT_W;
   localparam logic [63:0] ONES = '1;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst, clear, clear1, done, done1;
   logic [1:0] block_sel, block_sel1;

   binary_xnor_linear_if #(.BEAT_W(BEAT_W), .IN_BEATS(IN_BEATS), .OUT_CH(OUT_CH),
                           .NUM_BLOCKS(NUM_BLOCKS)) bus0 ();
   binary_xnor_linear_if #(.BEAT_W(BEAT_W), .IN_BEATS(1), .OUT_CH(OUT_CH),
                           .NUM_BLOCKS(NUM_BLOCKS)) bus1 ();

   binary_xnor_linear #(.BEAT_W(BEAT_W), .IN_BEATS(IN_BEATS), .OUT_CH(OUT_CH),
                        .NUM_BLOCKS(NUM_BLOCKS), .NUM_TOKENS(NUM_TOKENS),
                        .THRESH(THRESH)) dut0 (
      .clk(clk), .rst(rst), .clear(clear), .block_sel(block_sel), .done(done), .bus(bus0));

   binary_xnor_linear #(.BEAT_W(BEAT_W), .IN_BEATS(1), .OUT_CH(OUT_CH),
                        .NUM_BLOCKS(NUM_BLOCKS), .NUM_TOKENS(NUM_TOKENS),
                        .THRESH(THRESH)) dut1 (
      .clk(clk), .rst(rst), .clear(clear1), .block_sel(block_sel1), .done(done1), .bus(bus1));

   // Weight ROM images with one-cycle read latency
   logic [WD-1:0] rom0 [NUM_BLOCKS*IN_BEATS];
   logic [WD-1:0] rom1 [NUM_BLOCKS];
   int            addr_log [$];

   always @(posedge clk) begin
      if (bus0.w_rd_en) begin
         bus0.w_data <= rom0[bus0.w_addr];
         addr_log.push_back(int'(bus0.w_addr));
      end
      if (bus1.w_rd_en) bus1.w_data <= rom1[bus1.w_addr];
   end

   int vectors     = 0;
   int miscompares = 0;
   int tb_tok      = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Count agreeing bits per channel over every beat, then threshold.
   function automatic logic [63:0] model(input logic [63:0] x, input int sel,
                                         input int nb, input bit use1);
      logic [63:0]   r;
      logic [WD-1:0] w;
      int            acc;
      r = '0;
      for (int c = 0; c < OUT_CH; c++) begin
         acc = 0;
         for (int b = 0; b < nb; b++) begin
            w = use1 ? rom1[sel] : rom0[sel*nb + b];
            for (int i = 0; i < BEAT_W; i++)
               if (x[b*BEAT_W + i] == w[c*BEAT_W + i]) acc++;
         end
         r[c] = ((2*acc - nb*BEAT_W) > THRESH);
      end
      return r;
   endfunction

   function automatic logic [63:0] rnd64();
      return {$urandom, $urandom};
   endfunction

   // Present one token; returns at the negedge of the DRAIN cycle.
   task automatic send(input logic [63:0] x, input int sel, input int sel_late, input int gap);
      int w;
      for (int b = 0; b < IN_BEATS; b++) begin
         @(negedge clk);
         if (b > 0) begin
            repeat (gap) begin
               bus0.in_valid = 1'b0;
               chk("stall_rdy", bus0.in_ready, 1);
               @(negedge clk);
            end
         end
         bus0.in_data  = x[b*BEAT_W +: BEAT_W];
         block_sel     = 2'((b >= 2) ? sel_late : sel);
         bus0.in_valid = 1'b1;
         #1;
         w = 0;
         while (!bus0.in_ready && w < 50) begin
            @(negedge clk);
            #1;
            w++;
         end
         chk("beat_rdy", bus0.in_ready, 1);
         chk("rd_en", bus0.w_rd_en, 1);
         @(posedge clk);
      end
      @(negedge clk);
      bus0.in_valid = 1'b0;
   endtask

   // Starts in DRAIN; checks latency, hold stability and the handshake.
   task automatic recv(input logic [63:0] exp, input int hold);
      chk("drain_rdy", bus0.in_ready, 0);
      chk("drain_vld", bus0.out_valid, 0);
      bus0.out_ready = (hold == 0);
      @(negedge clk);
      chk("emit_vld", bus0.out_valid, 1);
      chk("emit_data", bus0.out_data, exp);
      chk("emit_done", done, 0);
      repeat (hold) begin
         @(negedge clk);
         chk("hold_vld", bus0.out_valid, 1);
         chk("hold_data", bus0.out_data, exp);
         chk("hold_rdy", bus0.in_ready, 0);
      end
      bus0.out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus0.out_ready = 1'b0;
      tb_tok++;
      chk("post_vld", bus0.out_valid, 0);
      chk("post_done", done, (tb_tok == NUM_TOKENS));
      chk("post_rdy", bus0.in_ready, (tb_tok != NUM_TOKENS));
   endtask

   task automatic do_clear();
      @(negedge clk);
      bus0.in_valid = 1'b0;
      clear = 1'b1;
      @(posedge clk);
      @(negedge clk);
      clear  = 1'b0;
      tb_tok = 0;
      #1;
      chk("clr_rdy", bus0.in_ready, 1);
   endtask

   initial begin
      #400000;
      $display("FAIL global_timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

   initial begin
      logic [63:0] x, e;
      logic [15:0] x1;
      int          s, g, h;

      // ROM: block0 all-0, block1 all-1, blocks 2/3 random; rom1 block0 all-1
      for (int en = 0; en < NUM_BLOCKS*IN_BEATS; en++) begin
         for (int k = 0; k < WD/32; k++) rom0[en][k*32 +: 32] = $urandom;
         if (en < IN_BEATS)        rom0[en] = '0;
         else if (en < 2*IN_BEATS) rom0[en] = '1;
      end
      for (int en = 0; en < NUM_BLOCKS; en++)
         for (int k = 0; k < WD/32; k++) rom1[en][k*32 +: 32] = $urandom;
      rom1[0] = '1;

      rst = 1'b1; clear = 1'b0; clear1 = 1'b0; block_sel = '0; block_sel1 = '0;
      bus0.in_data = '0; bus0.in_valid = 1'b0; bus0.out_ready = 1'b0;
      bus1.in_data = '0; bus1.in_valid = 1'b0; bus1.out_ready = 1'b0;

      // Reset state
      repeat (3) @(negedge clk);
      chk("rst_rdy", bus0.in_ready, 0);
      chk("rst_vld", bus0.out_valid, 0);
      chk("rst_data", bus0.out_data, 0);
      chk("rst_done", done, 0);
      chk("rst_rden", bus0.w_rd_en, 0);
      chk("rst_vld1", bus1.out_valid, 0);
      rst = 1'b0;
      @(negedge clk);
      chk("rel_rdy", bus0.in_ready, 1);
      chk("rel_rdy1", bus1.in_ready, 1);

      // Single-beat variant: all-ones vs all-ones weights, then random
      for (int k = 0; k < 3; k++) begin
         x1 = (k == 0) ? 16'hFFFF : 16'($urandom);
         s  = (k == 0) ? 0 : int'($urandom_range(1, 3));
         h  = (k == 0) ? 5 : 1;
         e  = (k == 0) ? ONES : model({48'b0, x1}, s, 1, 1'b1);
         @(negedge clk);
         bus1.in_data = x1; block_sel1 = 2'(s); bus1.in_valid = 1'b1;
         chk("t1_rdy", bus1.in_ready, 1);
         @(posedge clk);
         @(negedge clk);
         bus1.in_valid = 1'b0;
         chk("t1_drain_vld", bus1.out_valid, 0);
         @(negedge clk);
         chk("t1_vld", bus1.out_valid, 1);
         chk("t1_data", bus1.out_data, e);
         repeat (h) begin
            @(negedge clk);
            chk("t1_hold_vld", bus1.out_valid, 1);
            chk("t1_hold_data", bus1.out_data, e);
         end
         bus1.out_ready = 1'b1;
         @(posedge clk);
         @(negedge clk);
         bus1.out_ready = 1'b0;
         chk("t1_post_vld", bus1.out_valid, 0);
         chk("t1_post_rdy", bus1.in_ready, 1);
      end

      // Inverse weights, exact balance and one-over-balance
      send(ONES, 0, 0, 0);                       recv(64'h0, 2);
      send(64'h0, 1, 1, 0);                      recv(64'h0, 0);
      send(64'h0000_0000_FFFF_FFFF, 1, 1, 0);    recv(64'h0, 0);
      send(64'h0000_0001_FFFF_FFFF, 1, 1, 0);    recv(ONES, 0);

      // block_sel change mid-token is ignored
      addr_log.delete();
      x = rnd64();
      send(x, 2, 1, 0);
      recv(model(x, 2, IN_BEATS, 1'b0), 0);
      chk("addr_cnt", 64'(addr_log.size()), 4);
      for (int i = 0; i < 4; i++)
         if (i < addr_log.size()) chk("addr_seq", 64'(addr_log[i]), 64'(8 + i));

      // Gaps between beats give the same token as back-to-back
      x = rnd64();
      e = model(x, 3, IN_BEATS, 1'b0);
      send(x, 3, 3, 0); recv(e, 1);
      send(x, 3, 3, 3); recv(e, 1);

      // Random tokens, gaps and back-pressure
      for (int t = 0; t < 8; t++) begin
         x = rnd64();
         s = int'($urandom_range(0, 3));
         g = int'($urandom_range(0, 2));
         h = int'($urandom_range(0, 3));
         send(x, s, s, g);
         recv(model(x, s, IN_BEATS, 1'b0), h);
      end

      // clear mid-token discards the partial sum
      do_clear();
      @(negedge clk);
      bus0.in_data = 16'h1234; block_sel = 2'd2; bus0.in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus0.in_data = 16'hBEEF;
      @(posedge clk);
      do_clear();
      x = rnd64();
      send(x, 2, 2, 0); recv(model(x, 2, IN_BEATS, 1'b0), 0);

      // clear mid-EMIT drops out_valid
      x = rnd64();
      send(x, 3, 3, 0);
      @(negedge clk);
      chk("pre_clr_vld", bus0.out_valid, 1);
      do_clear();
      chk("clr_emit_vld", bus0.out_valid, 0);
      chk("clr_emit_data", bus0.out_data, 0);
      x = rnd64();
      send(x, 3, 3, 1); recv(model(x, 3, IN_BEATS, 1'b0), 0);

      // Full sequence to done
      do_clear();
      for (int t = 0; t < NUM_TOKENS; t++) begin
         x = rnd64();
         s = int'($urandom_range(0, 3));
         send(x, s, s, 0);
         recv(model(x, s, IN_BEATS, 1'b0), 0);
      end
      @(negedge clk);
      bus0.in_valid = 1'b1;
      #1;
      chk("done_rden", bus0.w_rd_en, 0);
      repeat (3) begin
         @(negedge clk);
         chk("done_rdy", bus0.in_ready, 0);
         chk("done_vld", bus0.out_valid, 0);
         chk("done_hold", done, 1);
      end
      bus0.in_valid = 1'b0;
      do_clear();
      chk("clr_done", done, 0);

      // rst during DRAIN of token 5
      for (int t = 0; t < 5; t++) begin
         x = rnd64();
         send(x, 2, 2, 0); recv(model(x, 2, IN_BEATS, 1'b0), 0);
      end
      send(rnd64(), 3, 3, 0);
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk("rst6_vld", bus0.out_valid, 0);
      chk("rst6_data", bus0.out_data, 0);
      chk("rst6_done", done, 0);
      chk("rst6_rdy", bus0.in_ready, 0);
      chk("rst6_rden", bus0.w_rd_en, 0);
      rst = 1'b0;
      tb_tok = 0;
      #1;
      chk("rst6_rel_rdy", bus0.in_ready, 1);
      x = rnd64();
      send(x, 2, 2, 0); recv(model(x, 2, IN_BEATS, 1'b0), 1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
